// File: rtl/pa_dtu_cdc_event_sync.sv
// Multi-channel toggle-event synchroniser: each src_tgl level change becomes one
// event, queued per channel and presented round-robin on a valid/ready output.

module pa_dtu_cdc_event_sync_ch #(
  parameter int SYNC  = 3,
  parameter int CNT_W = 3
) (
  input  logic dst_clk,
  input  logic dst_rst_b,
  input  logic i_tgl,
  input  logic i_init,
  input  logic i_load,
  input  logic i_ovf_clr,
  output logic o_pend_nz,
  output logic o_ovf
);
  logic [SYNC-1:0]  r_sync;
  logic             r_hist;
  logic [CNT_W-1:0] r_pend;
  logic             r_ovf;
  logic             w_det;
  logic             w_sat;
  logic             w_drop;

  // hist tracks sync_out every cycle, so during init it silently absorbs the reset-time level
  assign w_det  = !i_init && (r_sync[SYNC-1] ^ r_hist);
  assign w_sat  = &r_pend;
  assign w_drop = w_det && !i_load && w_sat;

  always_ff @(posedge dst_clk or negedge dst_rst_b) begin
    if (!dst_rst_b) begin
      r_sync <= '0;
      r_hist <= 1'b0;
      r_pend <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC-2:0], i_tgl};
      r_hist <= r_sync[SYNC-1];
      if (w_det && !i_load && !w_sat)
        r_pend <= r_pend + 1'b1;
      else if (i_load && !w_det)
        r_pend <= r_pend - 1'b1;
      r_ovf  <= (r_ovf && !i_ovf_clr) || w_drop;
    end
  end

  assign o_pend_nz = |r_pend;
  assign o_ovf     = r_ovf;
endmodule

module pa_dtu_cdc_event_sync #(
  parameter int CH    = 4,
  parameter int ID_W  = 2,
  parameter int SYNC  = 3,
  parameter int CNT_W = 3
) (
  input  logic            dst_clk,
  input  logic            dst_rst_b,
  input  logic [CH-1:0]   src_tgl,
  output logic            evt_vld,
  output logic [ID_W-1:0] evt_id,
  input  logic            evt_rdy,
  output logic [CH-1:0]   evt_ovf,
  input  logic            ovf_clr
);
  localparam int INIT_W = $clog2(SYNC + 2);

  logic [INIT_W-1:0] r_init;
  logic              r_vld;
  logic [ID_W-1:0]   r_id;
  logic [ID_W-1:0]   r_last;
  logic              w_init;
  logic              w_free;
  logic              w_gnt_vld;
  logic [ID_W-1:0]   w_gnt;
  logic              w_ld;
  logic [CH-1:0]     w_pend_nz;
  logic [CH-1:0]     w_load;
  int                w_best;
  int                w_dist;

  assign w_init = (r_init != INIT_W'(SYNC + 1));
  assign w_free = !r_vld || evt_rdy;

  // Round-robin: pick the requester at the smallest distance past last_grant
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    w_best    = CH;
    w_dist    = 0;
    for (int c = 0; c < CH; c++) begin
      w_dist = (c + CH - 1 - int'(r_last)) % CH;
      if (w_pend_nz[c] && (w_dist < w_best)) begin
        w_best    = w_dist;
        w_gnt_vld = 1'b1;
        w_gnt     = ID_W'(c);
      end
    end
  end

  assign w_ld = w_free && w_gnt_vld;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    assign w_load[g] = w_ld && (w_gnt == ID_W'(g));
    pa_dtu_cdc_event_sync_ch #(.SYNC(SYNC), .CNT_W(CNT_W)) u_ch (
      .dst_clk   (dst_clk),
      .dst_rst_b (dst_rst_b),
      .i_tgl     (src_tgl[g]),
      .i_init    (w_init),
      .i_load    (w_load[g]),
      .i_ovf_clr (ovf_clr),
      .o_pend_nz (w_pend_nz[g]),
      .o_ovf     (evt_ovf[g])
    );
  end

  always_ff @(posedge dst_clk or negedge dst_rst_b) begin
    if (!dst_rst_b) begin
      r_init <= '0;
      r_vld  <= 1'b0;
      r_id   <= '0;
      r_last <= ID_W'(CH - 1);
    end else begin
      if (w_init)
        r_init <= r_init + 1'b1;
      if (w_free) begin
        r_vld <= w_gnt_vld;
        if (w_gnt_vld) begin
          r_id   <= w_gnt;
          r_last <= w_gnt;
        end
      end
    end
  end

  assign evt_vld = r_vld;
  assign evt_id  = r_id;
endmodule

// File: tb/tb_pa_dtu_cdc_event_sync.sv
// Directed scenarios plus random traffic, checked every cycle against an
// event-queue model of the synchroniser.
module tb_pa_dtu_cdc_event_sync;
  localparam int CH    = 4;
  localparam int ID_W  = 2;
  localparam int SYNC  = 3;
  localparam int CNT_W = 3;
  localparam int PMAX  = (1 << CNT_W) - 1;

  logic            dst_clk = 1'b0;
  logic            dst_rst_b = 1'b0;
  logic [CH-1:0]   src_tgl = '0;
  logic            evt_rdy = 1'b0;
  logic            ovf_clr = 1'b0;
  logic            evt_vld;
  logic [ID_W-1:0] evt_id;
  logic [CH-1:0]   evt_ovf;

  int vec  = 0;
  int miss = 0;

  // model state
  logic [CH-1:0] samp[$];
  int            m_pend[CH];
  bit            m_vld;
  int            m_id;
  int            m_last;
  logic [CH-1:0] m_ovf;
  int            ids[$];

  pa_dtu_cdc_event_sync #(.CH(CH), .ID_W(ID_W), .SYNC(SYNC), .CNT_W(CNT_W)) dut (
    .dst_clk   (dst_clk),
    .dst_rst_b (dst_rst_b),
    .src_tgl   (src_tgl),
    .evt_vld   (evt_vld),
    .evt_id    (evt_id),
    .evt_rdy   (evt_rdy),
    .evt_ovf   (evt_ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 dst_clk = ~dst_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    samp.delete();
    for (int c = 0; c < CH; c++) m_pend[c] = 0;
    m_vld  = 0;
    m_id   = 0;
    m_last = CH - 1;
    m_ovf  = '0;
  endtask

  // A level change sampled at edge j becomes a queued event at edge j+SYNC;
  // changes seen before the post-reset settling window are ignored.
  task automatic model_edge(input logic [CH-1:0] s, input bit rdy, input bit clr);
    logic [CH-1:0] arr;
    int k, g;
    samp.push_back(s);
    k   = samp.size();
    arr = '0;
    if (k >= SYNC + 2) arr = samp[k-SYNC-1] ^ samp[k-SYNC-2];
    g = -1;
    if (!m_vld || rdy) begin
      for (int d = 1; d <= CH; d++) begin
        if (g < 0 && m_pend[(m_last + d) % CH] > 0) g = (m_last + d) % CH;
      end
      if (g >= 0) begin
        m_vld  = 1;
        m_id   = g;
        m_last = g;
        m_pend[g]--;
      end else begin
        m_vld = 0;
      end
    end
    if (clr) m_ovf = '0;
    for (int c = 0; c < CH; c++) begin
      if (arr[c]) begin
        if (m_pend[c] == PMAX) m_ovf[c] = 1'b1;
        else m_pend[c]++;
      end
    end
  endtask

  task automatic step();
    logic [CH-1:0] s;
    bit r, c;
    s = src_tgl;
    r = evt_rdy;
    c = ovf_clr;
    if (evt_vld && r) ids.push_back(int'(evt_id));
    @(posedge dst_clk);
    model_edge(s, r, c);
    #1;
    chk("vld", 32'(evt_vld), 32'(m_vld));
    if (m_vld) chk("id", 32'(evt_id), 32'(m_id));
    chk("ovf", 32'(evt_ovf), 32'(m_ovf));
  endtask

  task automatic do_reset();
    #2 dst_rst_b = 1'b0;
    #1;
    chk("rst_vld", 32'(evt_vld), 32'd0);
    chk("rst_id", 32'(evt_id), 32'd0);
    chk("rst_ovf", 32'(evt_ovf), 32'd0);
    model_reset();
    repeat (2) @(posedge dst_clk);
    #1 dst_rst_b = 1'b1;
  endtask

  initial begin
    int lat, ch;
    model_reset();
    #1;
    do_reset();
    evt_rdy = 1'b1;
    repeat (8) step();

    // single toggle latency
    src_tgl[2] = 1'b1;
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      step();
      if (evt_vld && lat == 0) lat = n;
    end
    chk("latency", 32'(lat), 32'd5);

    // simultaneous toggles, fresh arbitration
    do_reset();
    repeat (8) step();
    ids.delete();
    src_tgl = src_tgl ^ 4'hF;
    repeat (12) step();
    chk("sim_cnt", 32'(ids.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("sim_id", 32'((i < ids.size()) ? ids[i] : 99), 32'(i));
    ids.delete();
    src_tgl[0] = ~src_tgl[0];
    repeat (10) step();
    chk("ch0_cnt", 32'(ids.size()), 32'd1);
    chk("ch0_id", 32'((ids.size() > 0) ? ids[0] : 99), 32'd0);

    // backpressure and overflow on channel 1
    evt_rdy = 1'b0;
    for (int i = 0; i < 9; i++) begin
      src_tgl[1] = ~src_tgl[1];
      repeat (2) step();
    end
    repeat (6) step();
    chk("ovf1", 32'(evt_ovf[1]), 32'd1);
    ids.delete();
    evt_rdy = 1'b1;
    repeat (14) step();
    chk("drain_cnt", 32'(ids.size()), 32'd8);
    foreach (ids[i]) chk("drain_id", 32'(ids[i]), 32'd1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_clr", 32'(evt_ovf), 32'd0);

    // set wins over clear on channel 3
    evt_rdy = 1'b0;
    for (int i = 0; i < 9; i++) begin
      src_tgl[3] = ~src_tgl[3];
      repeat (2) step();
    end
    repeat (6) step();
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    src_tgl[3] = ~src_tgl[3];
    repeat (SYNC) step();
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("set_wins", 32'(evt_ovf[3]), 32'd1);
    evt_rdy = 1'b1;
    repeat (14) step();

    // input held high through reset
    src_tgl = 4'b1010;
    do_reset();
    ids.delete();
    repeat (10) step();
    chk("hi_rst_cnt", 32'(ids.size()), 32'd0);
    src_tgl[1] = 1'b0;
    repeat (10) step();
    chk("hi_rst_one", 32'(ids.size()), 32'd1);
    chk("hi_rst_id", 32'((ids.size() > 0) ? ids[0] : 99), 32'd1);

    // reset mid-stream
    evt_rdy = 1'b0;
    src_tgl = src_tgl ^ 4'b1101;
    repeat (8) step();
    chk("pre_rst_vld", 32'(evt_vld), 32'd1);
    do_reset();
    evt_rdy = 1'b1;
    ids.delete();
    repeat (20) step();
    chk("post_rst_cnt", 32'(ids.size()), 32'd0);

    // random traffic with periodic backpressure windows
    for (int n = 0; n < 1500; n++) begin
      if ($urandom % 4 == 0) begin
        ch = int'($urandom % CH);
        src_tgl[ch] = ~src_tgl[ch];
      end
      evt_rdy = ((n / 64) % 3 == 1) ? 1'b0 : ($urandom % 4 != 0);
      ovf_clr = ($urandom % 16 == 0);
      step();
    end
    ovf_clr = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
